insn_issue_buffer: RTL

Instruction issue buffer between instruction fetch and the control unit. It accepts fetched instruction words through a valid/ready handshake and holds them in a small circular FIFO. It presents the head entry to the control unit as `instr` and drives `pc_en` as the "instruction consumed this cycle" strobe. It absorbs decode stalls, drops everything on a pipeline flush, and stops issuing permanently once the control unit reports `halt` on a consumed instruction.

---
 rtl/insn_issue_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/insn_issue_buffer.sv
// rtl/insn_issue_buffer.sv - instruction issue buffer between fetch and the control unit
//
// Purpose: a small circular FIFO of {instr, pc, fault} entries. Fetch pushes
// through a valid/ready handshake. The head entry is presented to the control
// unit, and pc_en strobes when the head is consumed. The buffer absorbs decode
// stalls and drops all entries on a flush. Once a halt is taken on a presented
// instruction it stops issuing, and only RST releases it.
//
// Ports:
//   CLK, RST                  rising-edge clock, asynchronous active-high reset
//   fetch_valid/ready         fetch handshake; ready is combinational from state and flush
//   fetch_instr/pc/fault      fetched word, its PC and access-fault flag
//   instr/instr_pc/fault      head entry; NOP_WORD / 0 / 0 when empty
//   instr_valid               head entry valid
//   pc_en                     head consumed this cycle
//   decode_stall              downstream cannot take an instruction
//   flush                     discard all entries
//   halt                      control unit decoded a halt on the current instr
//   halted                    sticky halted status
//   occupancy                 number of valid entries
module insn_issue_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_fault,
  output logic                     fetch_ready,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     instr_fault,
  output logic                     instr_valid,
  output logic                     pc_en,
  input  logic                     decode_stall,
  input  logic                     flush,
  input  logic                     halt,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          mem_fault [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          halted_q;

  logic          push;
  logic          pop;
  logic          take_halt;

  assign instr_valid = ~halted_q & (count != '0);
  assign fetch_ready = ~halted_q & (count != FULL_COUNT) & ~flush;
  assign pc_en       = instr_valid & ~decode_stall & ~flush;
  assign push        = fetch_valid & fetch_ready;
  assign pop         = pc_en;

  // A halt counts when the head was presented and not stalled, even if a flush
  // arrives in the same cycle: the control unit has already seen the halt op.
  assign take_halt   = halt & instr_valid & ~decode_stall;

  assign instr       = instr_valid ? mem_instr[rd_ptr] : NOP_WORD;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : 32'h0;
  assign instr_fault = instr_valid ? mem_fault[rd_ptr] : 1'b0;
  assign halted      = halted_q;
  assign occupancy   = count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else if (take_halt) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b1;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr] <= fetch_instr;
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_fault[wr_ptr] <= fetch_fault;
    end
  end

endmodule
